// File: rtl/serial_byte_deframer.sv
// Serial frame receiver fed by a single-bit register stage, one bit per clk.
// Frame on the line: start (1), DATA_W data bits LSB first, optional parity,
// stop (0). Idle level is 0. Each good word is offered on a one-deep
// valid/ready holding register. frame_err pulses for one cycle on a bad stop
// bit or parity. overrun is sticky and means a good word was dropped.
//
// Handshake: a word moves to the consumer on a rising edge where
// out_valid && out_ready. out_data stays stable while out_valid is high.
// out_ready has no effect while out_valid is low. When a good frame finishes
// on the same edge as an accept, the new word replaces the old one and
// out_valid stays high.
module serial_byte_deframer #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic [1:0]        state_dbg
);

   localparam int   CNT_W      = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic PAR_TARGET = (PARITY_ODD != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    bit_cnt;
   logic [DATA_W-1:0]   shift_reg;
   logic                par_bad;

   assign state_dbg = state;

   // Receive FSM, holding register, error pulse and sticky overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_bad   <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         // Consumer takes the word; a good frame below may refill it.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (in_data) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  par_bad <= 1'b0;
               end
            end
            DATA: begin
               // LSB arrives first, so shifting in at the top leaves it at bit 0.
               shift_reg <= {in_data, shift_reg[DATA_W-1:1]};
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state <= (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
            PARITY: begin
               par_bad <= ((^shift_reg) ^ in_data) != PAR_TARGET;
               state   <= STOP;
            end
            STOP: begin
               // A 1 here is a bad stop bit, never a new start bit.
               if (!in_data && !par_bad) begin
                  if (!out_valid || out_ready) begin
                     out_data  <= shift_reg;
                     out_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
